alu_exec_unit: RTL and testbench

Multi-cycle RV32 execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder, plus two operands, and returns a 32-bit result with zero and illegal flags. Single-cycle logic ops complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter, and MUL runs on a 32-step shift-add multiplier. It sits in the execute stage, behind a valid/ready handshake on both input and output.

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_exec_unit_if.sv | 25 ++
 rtl/alu_seq_mul.sv | 50 +++++
 rtl/alu_exec_unit.sv | 131 +++++++++++++
 tb/tb_alu_exec_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 execution unit and the ALU control decoder:
// operation codes, FSM states, operand width and the single-cycle datapath function.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_MUL  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            illegal;
  } alu_resp_t;

  function automatic logic is_shift(alu_op_e op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

  // Result of every op that finishes in the accept cycle. Shifts return A,
  // which is only used when the shift amount is zero; MUL is never taken from here.
  function automatic alu_resp_t alu_single(logic [3:0] op, logic [XLEN-1:0] a,
                                           logic [XLEN-1:0] b);
    alu_resp_t r;
    r.result  = '0;
    r.illegal = 1'b0;
    case (op)
      ALU_AND:                   r.result = a & b;
      ALU_OR:                    r.result = a | b;
      ALU_XOR:                   r.result = a ^ b;
      ALU_ADD:                   r.result = a + b;
      ALU_SUB:                   r.result = a - b;
      ALU_SLT:                   r.result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:                  r.result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL, ALU_SRL, ALU_SRA: r.result = a;
      ALU_MUL:                   r.result = '0;
      default:                   r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between the issue logic and the execution unit.
interface alu_exec_unit_if;

  logic                      valid_i;
  logic                      ready_o;
  logic [3:0]                alu_control_op_i;
  logic [alu_pkg::XLEN-1:0]  operand_a_i;
  logic [alu_pkg::XLEN-1:0]  operand_b_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [alu_pkg::XLEN-1:0]  result_o;
  logic                      zero_o;
  logic                      illegal_o;

  modport master (
    output valid_i, alu_control_op_i, operand_a_i, operand_b_i, out_ready_i,
    input  ready_o, out_valid_o, result_o, zero_o, illegal_o
  );

  modport slave (
    input  valid_i, alu_control_op_i, operand_a_i, operand_b_i, out_ready_i,
    output ready_o, out_valid_o, result_o, zero_o, illegal_o
  );

endinterface

// File: rtl/alu_seq_mul.sv
// 32-step shift-add multiplier. done is high during the final iteration cycle and
// product then already includes that iteration, so the caller can capture on the same edge.
module alu_seq_mul
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            done,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [5:0]      cnt;
  logic            busy;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == 6'd1);
  assign product  = acc_next;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= multiplicand;
      mplier <= multiplier;
      acc    <= '0;
      cnt    <= 6'd32;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 6'd1;
      if (cnt == 6'd1) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32 execute unit: single-cycle logic/arith ops, 1-bit/cycle shifter
// and a sequenced shift-add multiplier behind valid/ready handshakes.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  alu_exec_unit_if.slave bus
);

  state_e          state;
  state_e          next_state;
  alu_op_e         op_in;
  alu_op_e         op_q;
  alu_resp_t       single;
  logic [4:0]      shamt_in;
  logic [XLEN-1:0] shift_reg;
  logic [XLEN-1:0] shift_next;
  logic [4:0]      shift_cnt;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic            accept;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  assign op_in     = alu_op_e'(bus.alu_control_op_i);
  assign shamt_in  = bus.operand_b_i[4:0];
  assign single    = alu_single(bus.alu_control_op_i, bus.operand_a_i, bus.operand_b_i);
  assign mul_start = accept && (op_in == ALU_MUL);

  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;

  alu_seq_mul u_mul (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .start       (mul_start),
    .multiplicand(bus.operand_a_i),
    .multiplier  (bus.operand_b_i),
    .done        (mul_done),
    .product     (mul_product)
  );

  always_comb begin
    case (op_q)
      ALU_SLL: shift_next = {shift_reg[XLEN-2:0], 1'b0};
      ALU_SRL: shift_next = {1'b0, shift_reg[XLEN-1:1]};
      ALU_SRA: shift_next = {shift_reg[XLEN-1], shift_reg[XLEN-1:1]};
      default: shift_next = shift_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state      = state;
    accept          = 1'b0;
    bus.ready_o     = 1'b0;
    bus.out_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.valid_i) begin
          accept = 1'b1;
          if (is_shift(op_in) && (shamt_in != 5'd0)) next_state = ST_SHIFT;
          else if (op_in == ALU_MUL)                 next_state = ST_MUL;
          else                                       next_state = ST_DONE;
        end
      end
      ST_SHIFT: if (shift_cnt == 5'd1) next_state = ST_DONE;
      ST_MUL:   if (mul_done)          next_state = ST_DONE;
      ST_DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) next_state = ST_IDLE;
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Flags are only set on the way into DONE and cleared on the way out, so they
  // read 0 whenever out_valid_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= ALU_AND;
      shift_reg <= '0;
      shift_cnt <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_q      <= op_in;
          shift_reg <= bus.operand_a_i;
          shift_cnt <= shamt_in;
          if (next_state == ST_DONE) begin
            result_q  <= single.result;
            zero_q    <= (single.result == '0);
            illegal_q <= single.illegal;
          end
        end
        ST_SHIFT: begin
          shift_reg <= shift_next;
          shift_cnt <= shift_cnt - 5'd1;
          if (shift_cnt == 5'd1) begin
            result_q <= shift_next;
            zero_q   <= (shift_next == '0);
          end
        end
        ST_MUL: if (mul_done) begin
          result_q <= mul_product;
          zero_q   <= (mul_product == '0);
        end
        ST_DONE: if (bus.out_ready_i) begin
          zero_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: requests push model expectations, a monitor
// pops and compares every consumed result and its latency.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if bus();

  alu_exec_unit dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    int          lat;
    int          acc_cycle;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   stall_mode = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the opcode table.
  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    longint unsigned p;
    int          sh;
    sh = int'(b[4:0]);
    e.result = 32'd0;
    e.illegal = 1'b0;
    e.lat = 1;
    e.acc_cycle = 0;
    case (op)
      4'b0000: e.result = a & b;
      4'b0001: e.result = a | b;
      4'b0010: e.result = a + b;
      4'b0110: e.result = a - b;
      4'b0011: e.result = a ^ b;
      4'b0111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: e.result = (a < b) ? 32'd1 : 32'd0;
      4'b1001: begin e.result = a << sh; e.lat = 1 + sh; end
      4'b1010: begin e.result = a >> sh; e.lat = 1 + sh; end
      4'b1011: begin e.result = 32'($signed(a) >>> sh); e.lat = 1 + sh; end
      4'b1100: begin
        p = longint'(a) * longint'(b);
        e.result = p[31:0];
        e.lat = 33;
      end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Consumer: drives out_ready_i shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0:       bus.out_ready_i = 1'b1;
      1:       bus.out_ready_i = ($urandom_range(0, 3) != 0);
      default: bus.out_ready_i = 1'b0;
    endcase
  end

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %h, expected no pending result", bus.result_o);
        end else begin
          if (!prev_valid)
            check("latency", 32'(cycle - sb_q[0].acc_cycle + 1), 32'(sb_q[0].lat));
          if (bus.out_ready_i) begin
            check("result", bus.result_o, sb_q[0].result);
            check("zero", 32'(bus.zero_o), 32'(sb_q[0].zero));
            check("illegal", 32'(bus.illegal_o), 32'(sb_q[0].illegal));
            void'(sb_q.pop_front());
          end
        end
      end else begin
        check("idle_flags", {30'd0, bus.zero_o, bus.illegal_o}, 32'd0);
      end
      prev_valid = bus.out_valid_o;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int acc);
    exp_t e;
    int   k;
    @(negedge clk);
    bus.alu_control_op_i = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    bus.valid_i = 1'b1;
    k = 0;
    while (!bus.ready_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!bus.ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready_o=0 for 500 cycles, expected 1");
      bus.valid_i = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    e = model(op, a, b);
    e.acc_cycle = cycle;
    acc = cycle;
    sb_q.push_back(e);
    bus.valid_i = 1'b0;
    bus.alu_control_op_i = 4'($urandom);
    bus.operand_a_i = $urandom;
    bus.operand_b_i = $urandom;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.out_valid_o) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  logic [3:0] legal_ops[11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0111,
                                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
  logic [3:0] bad_ops[5] = '{4'b0100, 4'b0101, 4'b1101, 4'b1110, 4'b1111};

  initial begin
    int a1;
    int a2;
    logic [3:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.alu_control_op_i = 4'd0;
    bus.operand_a_i = 32'd0;
    bus.operand_b_i = 32'd0;

    #3;
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_zero", 32'(bus.zero_o), 32'd0);
    check("rst_illegal", 32'(bus.illegal_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed boundary cases.
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, a1);
    issue(4'b0110, 32'd5, 32'd5, a1);
    issue(4'b1011, 32'h8000_0000, 32'd31, a1);
    issue(4'b1001, 32'hDEAD_BEEF, 32'd0, a1);
    issue(4'b1010, 32'h8000_0001, 32'd1, a1);
    issue(4'b1100, 32'hFFFF_FFFF, 32'd2, a1);
    issue(4'b1100, 32'd12345, 32'd6789, a1);
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, a1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, a1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1, a1);

    // Back-to-back single-cycle ops accept every second cycle.
    issue(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F, a1);
    issue(4'b0000, 32'hA5A5_A5A5, 32'h0F0F_0F0F, a2);
    check("throughput", 32'(a2 - a1), 32'd2);
    wait_drain();

    // Backpressure: result held, no accept while DONE.
    stall_mode = 2;
    @(posedge clk);
    #2;
    issue(4'b0010, 32'd100, 32'd23, a1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ready", 32'(bus.ready_o), 32'd0);
      check("hold_valid", 32'(bus.out_valid_o), 32'd1);
      check("hold_result", bus.result_o, 32'd123);
      if (i == 3) begin
        bus.alu_control_op_i = 4'b0010;
        bus.operand_a_i = 32'd1;
        bus.operand_b_i = 32'd1;
        bus.valid_i = 1'b1;
      end else begin
        bus.valid_i = 1'b0;
      end
    end
    bus.valid_i = 1'b0;
    stall_mode = 0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("no_stray_accept", 32'(bus.out_valid_o), 32'd0);

    // Randomized traffic with random backpressure.
    stall_mode = 1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 4)];
      else                           op = legal_ops[$urandom_range(0, 10)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) ra = rb;
      issue(op, ra, rb, a1);
    end
    wait_drain();
    stall_mode = 0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.alu_control_op_i = 4'b1100;
    bus.operand_a_i = 32'd7;
    bus.operand_b_i = 32'd9;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready_o), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("abort_result", bus.result_o, 32'd0);
    check("abort_zero", 32'(bus.zero_o), 32'd0);
    check("abort_illegal", 32'(bus.illegal_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(4'b0010, 32'd2, 32'd3, a1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
